// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, sizes and helpers for the 4x4 keypad scanner.
//   state_e    : scanner FSM states
//   KEY_W/ROWS/COLS : key code width and matrix dimensions
//   is_onehot  : exactly-one-bit-set test for a 4-bit vector
//   oh2idx     : one-hot to index, bit3 maps to index 0
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, REPORT, RELEASE} state_e;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0) && ((v & (v - 4'b1)) == 4'b0);
    endfunction

    // Row/column bit 3 is physical line 0, so the index counts down the vector.
    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        return oh[3] ? 2'd0 : oh[2] ? 2'd1 : oh[1] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if: keypad matrix / ring counter / consumer signal bundle.
//   col_onehot : one-hot column phase from the ring counter
//   row_in     : asynchronous active-high keypad rows (bit3 = row0)
//   key_ack    : consumer accepts key_code
//   cnt_en     : one-cycle advance pulse to the ring counter
//   key_code   : {row_idx, col_idx}
//   key_valid  : key_code valid, held until acknowledged
//   err_multi  : pulse when several rows are active at a sample point
//   master = environment side, slave = scanner side
interface keypad_scan_ctrl_if;
    import keypad_pkg::*;

    logic [COLS-1:0]  col_onehot;
    logic [ROWS-1:0]  row_in;
    logic             key_ack;
    logic             cnt_en;
    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             err_multi;

    modport master (
        output col_onehot, row_in, key_ack,
        input  cnt_en, key_code, key_valid, err_multi
    );

    modport slave (
        input  col_onehot, row_in, key_ack,
        output cnt_en, key_code, key_valid, err_multi
    );

endinterface

// File: rtl/keypad_scan_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a W-bit asynchronous bus.
//   clk  : destination clock
//   rstn : asynchronous active-low reset, clears both stages
//   d_i  : asynchronous input
//   q_o  : synchronized output
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= '0;
            q_o    <= '0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with debounce and valid/ack report.
//   clk  : system clock, rising edge
//   rstn : asynchronous active-low reset
//   kp   : slave side of keypad_scan_ctrl_if (column phase, rows, ack in;
//          ring advance, key code/valid, multi-row error out)
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rstn,
    keypad_scan_ctrl_if.slave  kp
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    logic [ROWS-1:0]  row_s;
    state_e           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [CW-1:0]    dbc_q, dbc_d;
    logic [ROWS-1:0]  row_q, row_d;
    logic [1:0]       col_q, col_d;
    logic [KEY_W-1:0] code_q, code_d;
    logic             valid_q, valid_d;
    logic             sample, hit;

    sync_2ff #(.W(ROWS)) u_row_sync (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (kp.row_in),
        .q_o  (row_s)
    );

    assign sample = (state_q == SCAN) && (div_q == DIV_LAST);
    // A single row on a well-formed column phase is the only sample that holds the ring.
    assign hit    = is_onehot(row_s) && is_onehot(kp.col_onehot);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SCAN;
            div_q   <= '0;
            dbc_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            dbc_q   <= dbc_d;
            row_q   <= row_d;
            col_q   <= col_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        // The divider only runs in SCAN, so every re-entry to SCAN starts from zero.
        div_d   = (state_q == SCAN && !sample) ? div_q + 1'b1 : '0;
        dbc_d   = dbc_q;
        row_d   = row_q;
        col_d   = col_q;
        code_d  = code_q;
        valid_d = valid_q;
        unique case (state_q)
            SCAN: begin
                if (sample && hit) begin
                    state_d = DEBOUNCE;
                    row_d   = row_s;
                    col_d   = oh2idx(kp.col_onehot);
                    dbc_d   = '0;
                end
            end
            DEBOUNCE: begin
                if (row_s != row_q) begin
                    state_d = SCAN;
                end else if (dbc_q == DB_LAST) begin
                    state_d = REPORT;
                    code_d  = {oh2idx(row_q), col_q};
                    valid_d = 1'b1;
                end else begin
                    dbc_d = dbc_q + 1'b1;
                end
            end
            REPORT: begin
                if (kp.key_ack) begin
                    state_d = RELEASE;
                    valid_d = 1'b0;
                    dbc_d   = '0;
                end
            end
            RELEASE: begin
                if (row_s != '0) begin
                    dbc_d = '0;
                end else if (dbc_q == DB_LAST) begin
                    state_d = SCAN;
                end else begin
                    dbc_d = dbc_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        kp.cnt_en    = sample && !hit;
        kp.err_multi = sample && is_onehot(kp.col_onehot) && (row_s != '0) && !is_onehot(row_s);
        kp.key_code  = code_q;
        kp.key_valid = valid_q;
    end

endmodule
